// File: rtl/inv_stage.sv
// Grasshopper (GOST R 34.12-2015) iterative block decryption engine.
// One block in flight: X[K10], then nine rounds of L^-1, S^-1, X[Ki] for i = 9..1.

module key_xor (
    input  logic [3:0]   i_stage_num,
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);
    logic [127:0] w_key;

    // Round keys expanded from the standard test key 8899aabb...0123456789abcdef
    always_comb begin
        w_key = '0;
        case (i_stage_num)
            4'd1:    w_key = 128'h8899aabbccddeeff0011223344556677;
            4'd2:    w_key = 128'hfedcba98765432100123456789abcdef;
            4'd3:    w_key = 128'hdb31485315694343228d6aef8cc78c44;
            4'd4:    w_key = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
            4'd5:    w_key = 128'h57646468c44a5e28d3e59246f429f1ac;
            4'd6:    w_key = 128'hbd079435165c6432b532e82834da581b;
            4'd7:    w_key = 128'h51e640757e8745de705727265a0098b1;
            4'd8:    w_key = 128'h5a7925017b9fdd3ed72a91a22286f984;
            4'd9:    w_key = 128'hbb44e25378c73123a5f32f73cdb6e517;
            4'd10:   w_key = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
            default: w_key = '0;
        endcase
    end

    assign o_data = i_data ^ w_key;
endmodule

module inv_stage #(
    parameter int unsigned R_STEPS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o,
    output logic         busy
);
    localparam int unsigned LCYC  = 16 / R_STEPS;
    localparam int unsigned CNT_W = (LCYC > 1) ? $clog2(LCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LCYC - 1);

    localparam logic [0:255][7:0] PI = {
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // l() coefficients indexed by byte position: [15] multiplies a15, [0] multiplies a0
    localparam logic [15:0][7:0] LC = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    function automatic logic [0:255][7:0] f_build_inv();
        logic [0:255][7:0] t;
        t = '0;
        for (int unsigned j = 0; j < 256; j++) t[PI[j]] = j[7:0];
        return t;
    endfunction

    localparam logic [0:255][7:0] PI_INV = f_build_inv();

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hc3) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] f_l(input logic [127:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 16; i++) acc = acc ^ f_gmul(v[8*i +: 8], LC[i]);
        return acc;
    endfunction

    // One inverse R step: shift up one byte, new a0 = l(a14..a0, a15)
    function automatic logic [127:0] f_linv(input logic [127:0] w);
        logic [127:0] v;
        v = w;
        for (int unsigned s = 0; s < R_STEPS; s++) v = {v[119:0], f_l({v[119:0], v[127:120]})};
        return v;
    endfunction

    function automatic logic [127:0] f_sinv(input logic [127:0] w);
        logic [127:0] v;
        v = '0;
        for (int unsigned b = 0; b < 16; b++) v[8*b +: 8] = PI_INV[w[8*b +: 8]];
        return v;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LINV, S_SINV, S_DONE} state_t;

    state_t             r_state, w_state_nx;
    logic [127:0]       r_work, r_data_o;
    logic [3:0]         r_round;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid_o;
    logic               w_idle;
    logic [3:0]         w_stage;
    logic [127:0]       w_kx_in, w_kx_out, w_linv, w_sinv;

    assign w_idle   = (r_state == S_IDLE);
    assign w_linv   = f_linv(r_work);
    assign w_sinv   = f_sinv(r_work);
    assign w_stage  = w_idle ? 4'd10 : r_round;
    assign w_kx_in  = w_idle ? data_i : w_sinv;

    key_xor u_key_xor (
        .i_stage_num (w_stage),
        .i_data      (w_kx_in),
        .o_data      (w_kx_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (valid_i) w_state_nx = S_LINV;
            S_LINV:  if (r_cnt == CNT_LAST) w_state_nx = S_SINV;
            S_SINV:  w_state_nx = (r_round == 4'd1) ? S_DONE : S_LINV;
            S_DONE:  if (ready_i) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work    <= '0;
            r_data_o  <= '0;
            r_round   <= '0;
            r_cnt     <= '0;
            r_valid_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (valid_i) begin
                    r_work  <= w_kx_out;
                    r_round <= 4'd9;
                    r_cnt   <= '0;
                end
                S_LINV: begin
                    r_work <= w_linv;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                S_SINV: begin
                    r_work <= w_kx_out;
                    if (r_round == 4'd1) begin
                        r_data_o  <= w_kx_out;
                        r_valid_o <= 1'b1;
                    end else begin
                        r_round <= r_round - 4'd1;
                        r_cnt   <= '0;
                    end
                end
                S_DONE: if (ready_i) r_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy    = ~w_idle;
    assign ready_o = w_idle;
    assign valid_o = r_valid_o;
    assign data_o  = r_data_o;
endmodule
